// File: rtl/spi_pu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pu_pkg
// Description : Shared definitions for the SPI send/receive processing units.
//               The byte width and the FSM state encoding are shared by both
//               ends of the link so that they always agree.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pu_pkg;

   localparam int SPI_BYTE_BITS = 8;

   // Explicit 3-bit encoding keeps the state register width fixed.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAD  = 3'd1,
      SHIFT = 3'd2,
      TRAIL = 3'd3,
      GAP   = 3'd4
   } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_spi_send.sv
`default_nettype none
// ============================================================================
// Module      : fifo_spi_send
// Description : Single-clock synchronous FIFO with first-word fall-through
//               read data. Holds {last, data} entries for the SPI sender.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_wr_en/i_wr_data - write request and entry
//               i_rd_en/o_rd_data - pop request and head entry
//               o_full/o_empty    - registered status flags
//               o_level           - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_spi_send #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 9
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] c_full_level = LW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             r_full;
   logic             r_empty;

   logic             w_bypass;
   logic             w_do_wr;
   logic             w_do_rd;
   logic [LW-1:0]    w_level_nxt;

   // Read and write together while empty passes the word straight through,
   // so nothing is stored and the level stays at zero.
   assign w_bypass = r_empty && i_rd_en && i_wr_en;
   // A write while full is only taken when the same cycle frees a slot.
   assign w_do_wr  = i_wr_en && (!r_full || i_rd_en) && !w_bypass;
   assign w_do_rd  = i_rd_en && !r_empty;

   always_comb begin
      w_level_nxt = r_level;
      if (w_do_wr && !w_do_rd) begin
         w_level_nxt = r_level + 1'b1;
      end else if (!w_do_wr && w_do_rd) begin
         w_level_nxt = r_level - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == c_full_level);
         r_empty <= (w_level_nxt == '0);
      end
   end

   // Storage needs no reset; validity is tracked by the pointers and level.
   always_ff @(posedge clk) begin
      if (w_do_wr) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   assign o_rd_data = w_bypass ? i_wr_data : r_mem[r_rd_ptr];
   assign o_full    = r_full;
   assign o_empty   = r_empty;
   assign o_level   = r_level;

endmodule
`default_nettype wire

// File: rtl/spi_send_pu.sv
`default_nettype none
// ============================================================================
// Module      : spi_send_pu
// Description : SPI master transmit unit. Buffers framed bytes in a FIFO and
//               shifts them out MSB first (mode 0) with spi_cs held high for
//               the whole package.
// Ports       : axi_aclk, axi_areset      - clock, sync active-high reset
//               tx_data/tx_last/tx_valid  - byte write with package framing
//               tx_ready                  - FIFO not full
//               spi_clk/spi_mosi/spi_cs   - SPI link
//               package_start_int/_end_int - one-cycle package boundary pulses
//               tx_busy                   - FSM active or bytes pending
// Revision    : 1.0 - initial release
// ============================================================================
module spi_send_pu
   import spi_pu_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                     axi_aclk,
   input  logic                     axi_areset,
   input  logic [SPI_BYTE_BITS-1:0] tx_data,
   input  logic                     tx_last,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   output logic                     spi_clk,
   output logic                     spi_mosi,
   output logic                     spi_cs,
   output logic                     package_start_int,
   output logic                     package_end_int,
   output logic                     tx_busy
);

   localparam int DW = $clog2(CLK_DIV) + 1;
   localparam logic [DW-1:0] c_div_max  = DW'(CLK_DIV - 1);
   localparam logic [2:0]    c_last_bit = 3'(SPI_BYTE_BITS - 1);

   spi_state_t               r_state;
   logic [DW-1:0]            r_div_cnt;
   logic [2:0]               r_bit_cnt;
   logic [SPI_BYTE_BITS-1:0] r_shift;
   logic                     r_last;
   logic                     r_stall;
   logic                     r_spi_clk;
   logic                     r_spi_mosi;
   logic                     r_spi_cs;
   logic                     r_start;
   logic                     r_end;

   logic                     w_fifo_wr;
   logic                     w_fifo_rd;
   logic [SPI_BYTE_BITS:0]   w_fifo_rdata;
   logic                     w_fifo_full;
   logic                     w_fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] w_fifo_level;
   logic                     w_div_done;
   logic                     w_byte_done;

   assign w_fifo_wr   = tx_valid && !w_fifo_full;
   assign w_div_done  = (r_div_cnt == c_div_max);
   // The eighth falling edge of the current byte happens this cycle.
   assign w_byte_done = (r_state == SHIFT) && w_div_done && r_spi_clk &&
                        (r_bit_cnt == c_last_bit);
   // Pop on package start, on data arriving after an underrun, or at a byte
   // boundary inside a package that continues.
   assign w_fifo_rd   = !w_fifo_empty &&
                        ((r_state == IDLE) ||
                         ((r_state == LEAD) && r_stall) ||
                         (w_byte_done && !r_last));

   fifo_spi_send #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SPI_BYTE_BITS + 1)
   ) u_fifo (
      .clk       (axi_aclk),
      .rst       (axi_areset),
      .i_wr_en   (w_fifo_wr),
      .i_wr_data ({tx_last, tx_data}),
      .i_rd_en   (w_fifo_rd),
      .o_rd_data (w_fifo_rdata),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty),
      .o_level   (w_fifo_level)
   );

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         r_state    <= IDLE;
         r_div_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_last     <= 1'b0;
         r_stall    <= 1'b0;
         r_spi_clk  <= 1'b0;
         r_spi_mosi <= 1'b0;
         r_spi_cs   <= 1'b0;
         r_start    <= 1'b0;
         r_end      <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_end   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_fifo_empty) begin
                  r_shift    <= w_fifo_rdata[SPI_BYTE_BITS-1:0];
                  r_last     <= w_fifo_rdata[SPI_BYTE_BITS];
                  r_spi_mosi <= w_fifo_rdata[SPI_BYTE_BITS-1];
                  r_spi_cs   <= 1'b1;
                  r_start    <= 1'b1;
                  r_stall    <= 1'b0;
                  r_div_cnt  <= '0;
                  r_state    <= LEAD;
               end
            end
            LEAD: begin
               // r_stall marks an underrun: hold the link until a byte
               // arrives, then give it a full setup period.
               if (r_stall) begin
                  if (!w_fifo_empty) begin
                     r_shift    <= w_fifo_rdata[SPI_BYTE_BITS-1:0];
                     r_last     <= w_fifo_rdata[SPI_BYTE_BITS];
                     r_spi_mosi <= w_fifo_rdata[SPI_BYTE_BITS-1];
                     r_stall    <= 1'b0;
                     r_div_cnt  <= '0;
                  end
               end else if (w_div_done) begin
                  r_spi_clk <= 1'b1;
                  r_div_cnt <= '0;
                  r_bit_cnt <= '0;
                  r_state   <= SHIFT;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (w_div_done) begin
                  r_div_cnt <= '0;
                  r_spi_clk <= !r_spi_clk;
                  if (r_spi_clk) begin
                     if (r_bit_cnt == c_last_bit) begin
                        if (r_last) begin
                           r_state <= TRAIL;
                        end else if (!w_fifo_empty) begin
                           r_shift    <= w_fifo_rdata[SPI_BYTE_BITS-1:0];
                           r_last     <= w_fifo_rdata[SPI_BYTE_BITS];
                           r_spi_mosi <= w_fifo_rdata[SPI_BYTE_BITS-1];
                           r_bit_cnt  <= '0;
                        end else begin
                           r_stall <= 1'b1;
                           r_state <= LEAD;
                        end
                     end else begin
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        r_spi_mosi <= r_shift[SPI_BYTE_BITS-2];
                        r_shift    <= {r_shift[SPI_BYTE_BITS-2:0], 1'b0};
                     end
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            TRAIL: begin
               if (w_div_done) begin
                  r_spi_cs   <= 1'b0;
                  r_end      <= 1'b1;
                  r_spi_mosi <= 1'b0;
                  r_div_cnt  <= '0;
                  r_state    <= GAP;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            GAP: begin
               if (w_div_done) begin
                  r_div_cnt <= '0;
                  r_state   <= IDLE;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign tx_ready          = !w_fifo_full;
   assign spi_clk           = r_spi_clk;
   assign spi_mosi          = r_spi_mosi;
   assign spi_cs            = r_spi_cs;
   assign package_start_int = r_start;
   assign package_end_int   = r_end;
   assign tx_busy           = (r_state != IDLE) || (w_fifo_level != '0);

endmodule
`default_nettype wire

// File: tb/tb_spi_send_pu.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_send_pu
// Description : Self-checking bench for spi_send_pu. A monitor reconstructs
//               packages from the SPI pins; directed tables, hand-written
//               corner sequences and random packages are compared against
//               values derived from the link timing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_send_pu;

   localparam int CLK_DIV    = 2;
   localparam int FIFO_DEPTH = 4;

   logic       axi_aclk   = 1'b0;
   logic       axi_areset = 1'b1;
   logic [7:0] tx_data    = 8'h00;
   logic       tx_last    = 1'b0;
   logic       tx_valid   = 1'b0;
   logic       tx_ready;
   logic       spi_clk;
   logic       spi_mosi;
   logic       spi_cs;
   logic       package_start_int;
   logic       package_end_int;
   logic       tx_busy;

   spi_send_pu #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .axi_aclk          (axi_aclk),
      .axi_areset        (axi_areset),
      .tx_data           (tx_data),
      .tx_last           (tx_last),
      .tx_valid          (tx_valid),
      .tx_ready          (tx_ready),
      .spi_clk           (spi_clk),
      .spi_mosi          (spi_mosi),
      .spi_cs            (spi_cs),
      .package_start_int (package_start_int),
      .package_end_int   (package_end_int),
      .tx_busy           (tx_busy)
   );

   always #5 axi_aclk = ~axi_aclk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- pin monitor ----------------
   int         cyc = 0;
   always @(posedge axi_aclk) cyc <= cyc + 1;

   logic       prev_cs = 1'b0, prev_clk = 1'b0, prev_mosi = 1'b0;
   int         cs_len = 0, nrise = 0, gap_cnt = 1000, gap_run = 0;
   int         cs_rise_cyc = 0, mosi_chg = 0;
   int         start_cnt = 0, end_cnt = 0, clk_viol = 0, pkg_done = 0;
   int         last_len = 0, last_rise = 0, last_gap = 0;
   int         rise_off [64];
   int         chg_gap  [64];
   logic [7:0] sh = 8'h00;
   logic [7:0] q_byte [$];

   always @(negedge axi_aclk) begin
      if (axi_areset) begin
         prev_cs   = 1'b0;
         prev_clk  = 1'b0;
         prev_mosi = 1'b0;
         gap_cnt   = 1000;
      end else begin
         if (spi_mosi != prev_mosi) mosi_chg = cyc;
         if (package_start_int) start_cnt++;
         if (package_end_int) end_cnt++;
         if (!spi_cs) gap_cnt++;
         if (!spi_cs && spi_clk) clk_viol++;
         if (spi_cs && !prev_cs) begin
            check("start_at_cs_rise", int'(package_start_int), 1);
            gap_run     = gap_cnt;
            cs_len      = 0;
            nrise       = 0;
            cs_rise_cyc = cyc;
         end
         if (spi_cs) cs_len++;
         if (spi_clk && !prev_clk) begin
            if (nrise < 64) begin
               rise_off[nrise] = cyc - cs_rise_cyc;
               chg_gap[nrise]  = cyc - mosi_chg;
            end
            sh = {sh[6:0], spi_mosi};
            nrise++;
            if (nrise % 8 == 0) q_byte.push_back(sh);
         end
         if (!spi_cs && prev_cs) begin
            check("end_at_cs_fall", int'(package_end_int), 1);
            last_len  = cs_len;
            last_rise = nrise;
            last_gap  = gap_run;
            pkg_done++;
            gap_cnt   = 1;
         end
         prev_cs   = spi_cs;
         prev_clk  = spi_clk;
         prev_mosi = spi_mosi;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input logic [7:0] d, input logic l);
      int t = 0;
      while (!tx_ready && t < 2000) begin
         @(posedge axi_aclk); #1; t++;
      end
      if (!tx_ready) check("push_ready_timeout", 0, 1);
      tx_data  = d;
      tx_last  = l;
      tx_valid = 1'b1;
      @(posedge axi_aclk); #1;
      tx_valid = 1'b0;
   endtask

   task automatic wait_pkgs(input int target);
      int t = 0;
      while (pkg_done < target && t < 5000) begin
         @(posedge axi_aclk); #1; t++;
      end
      if (pkg_done < target) check("pkg_timeout", pkg_done, target);
   endtask

   task automatic wait_cs();
      int t = 0;
      while (!spi_cs && t < 200) begin
         @(posedge axi_aclk); #1; t++;
      end
      if (!spi_cs) check("cs_timeout", 0, 1);
   endtask

   task automatic expect_byte(input string name, input logic [7:0] exp);
      if (q_byte.size() == 0) check(name, -1, int'(exp));
      else check(name, int'(q_byte.pop_front()), int'(exp));
   endtask

   typedef struct {
      int          n;
      logic [23:0] d;
      int          exp_len;
      int          exp_rise;
   } vec_t;

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      vec_t tbl [5];
      logic exp_rdy [6];
      int   base, s0, e0;

      tbl[0] = '{1, 24'hA5_0000, 34, 8};
      tbl[1] = '{2, 24'h3CFF_00, 66, 16};
      tbl[2] = '{1, 24'h11_0000, 34, 8};
      tbl[3] = '{3, 24'hFF0180, 98, 24};
      tbl[4] = '{2, 24'h00C3_00, 66, 16};
      exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      // Reset state
      repeat (3) @(posedge axi_aclk);
      #1;
      check("rst_tx_ready", int'(tx_ready), 1);
      check("rst_spi_cs", int'(spi_cs), 0);
      check("rst_spi_clk", int'(spi_clk), 0);
      check("rst_spi_mosi", int'(spi_mosi), 0);
      check("rst_start", int'(package_start_int), 0);
      check("rst_end", int'(package_end_int), 0);
      check("rst_busy", int'(tx_busy), 0);
      axi_areset = 1'b0;
      @(posedge axi_aclk); #1;

      // Directed packages
      for (int i = 0; i < 5; i++) begin
         base = pkg_done; s0 = start_cnt; e0 = end_cnt;
         for (int b = 0; b < tbl[i].n; b++)
            push(tbl[i].d[23-8*b -: 8], (b == tbl[i].n - 1));
         wait_pkgs(base + 1);
         check("tbl_cs_len", last_len, tbl[i].exp_len);
         check("tbl_rises", last_rise, tbl[i].exp_rise);
         for (int b = 0; b < tbl[i].n; b++)
            expect_byte("tbl_byte", tbl[i].d[23-8*b -: 8]);
         check("tbl_start_pulses", start_cnt - s0, 1);
         check("tbl_end_pulses", end_cnt - e0, 1);
         if (i == 0)
            for (int k = 0; k < 8; k++)
               check("rise_offset", rise_off[k], CLK_DIV + 2*CLK_DIV*k);
      end

      // Underrun between two bytes of one package
      base = pkg_done; s0 = start_cnt; e0 = end_cnt;
      push(8'h81, 1'b0);
      repeat (100) @(posedge axi_aclk);
      #1;
      check("underrun_cs_held", int'(spi_cs), 1);
      check("underrun_clk_low", int'(spi_clk), 0);
      push(8'h7E, 1'b1);
      wait_pkgs(base + 1);
      check("underrun_rises", last_rise, 16);
      expect_byte("underrun_byte0", 8'h81);
      expect_byte("underrun_byte1", 8'h7E);
      check("underrun_setup", chg_gap[8], CLK_DIV);
      check("underrun_stretch", int'((rise_off[8] - rise_off[7]) > 8*CLK_DIV), 1);
      check("underrun_start_pulses", start_cnt - s0, 1);
      check("underrun_end_pulses", end_cnt - e0, 1);

      // FIFO full while the link is busy with the first byte
      base = pkg_done;
      push(8'h01, 1'b0);
      wait_cs();
      for (int k = 0; k < 6; k++) begin
         tx_data  = 8'(8'h02 + k);
         tx_last  = (k >= 3);
         tx_valid = 1'b1;
         check("full_tx_ready", int'(tx_ready), int'(exp_rdy[k]));
         @(posedge axi_aclk); #1;
      end
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      wait_pkgs(base + 1);
      check("full_cs_len", last_len, CLK_DIV*(17 + 16*4));
      check("full_rises", last_rise, 40);
      for (int k = 0; k < 5; k++)
         expect_byte("full_byte", 8'(8'h01 + k));
      repeat (60) @(posedge axi_aclk);
      #1;
      check("full_no_extra_pkg", pkg_done, base + 1);
      check("full_idle_busy", int'(tx_busy), 0);

      // Two queued single-byte packages
      base = pkg_done; s0 = start_cnt; e0 = end_cnt;
      push(8'h11, 1'b1);
      push(8'h22, 1'b1);
      wait_pkgs(base + 2);
      check("queued_gap", last_gap, CLK_DIV + 1);
      check("queued_len", last_len, 17*CLK_DIV);
      expect_byte("queued_byte0", 8'h11);
      expect_byte("queued_byte1", 8'h22);
      check("queued_start_pulses", start_cnt - s0, 2);
      check("queued_end_pulses", end_cnt - e0, 2);

      // Reset in the middle of a byte
      base = pkg_done; e0 = end_cnt;
      push(8'hA5, 1'b1);
      wait_cs();
      repeat (10) @(posedge axi_aclk);
      #1;
      axi_areset = 1'b1;
      @(posedge axi_aclk); #1;
      check("mid_rst_cs", int'(spi_cs), 0);
      check("mid_rst_clk", int'(spi_clk), 0);
      check("mid_rst_end", int'(package_end_int), 0);
      check("mid_rst_ready", int'(tx_ready), 1);
      check("mid_rst_busy", int'(tx_busy), 0);
      axi_areset = 1'b0;
      @(posedge axi_aclk); #1;
      check("mid_rst_no_end", end_cnt - e0, 0);
      push(8'h5A, 1'b1);
      wait_pkgs(base + 1);
      check("post_rst_len", last_len, 17*CLK_DIV);
      check("post_rst_rises", last_rise, 8);
      expect_byte("post_rst_byte", 8'h5A);

      // Random packages against the timing-rule model
      for (int p = 0; p < 12; p++) begin
         int         n;
         logic       gapped;
         logic [7:0] eb [3];
         n      = $urandom_range(1, 3);
         gapped = ($urandom_range(0, 1) == 1);
         base   = pkg_done;
         for (int b = 0; b < n; b++) eb[b] = 8'($urandom_range(0, 255));
         for (int b = 0; b < n; b++) begin
            if (gapped && b > 0) begin
               repeat ($urandom_range(0, 40)) @(posedge axi_aclk);
               #1;
            end
            push(eb[b], (b == n - 1));
         end
         wait_pkgs(base + 1);
         check("rand_rises", last_rise, 8*n);
         if (!gapped) check("rand_cs_len", last_len, CLK_DIV*(17 + 16*(n - 1)));
         for (int b = 0; b < n; b++) expect_byte("rand_byte", eb[b]);
      end

      check("clk_while_cs_low", clk_viol, 0);
      check("leftover_bytes", q_byte.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
